// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: opcode constants, ALU function encodings and
// the decoded-operation payload passed from decode to the ALU.
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // alu_op_mod selects SUB for ALU_ADD and SRA for ALU_SRL.
   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SLL  = 3'b001,
      ALU_LT   = 3'b010,
      ALU_LTU  = 3'b011,
      ALU_XOR  = 3'b100,
      ALU_SRL  = 3'b101,
      ALU_OR   = 3'b110,
      ALU_AND  = 3'b111
   } alu_op_e;

   typedef struct packed {
      alu_op_e         op;
      logic            op_mod;
      logic [XLEN-1:0] lhs;
      logic [XLEN-1:0] rhs;
      logic [4:0]      rd;
      logic            rd_write;
      logic            illegal;
   } dec_payload_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry pipeline buffer: a registered output stage plus one skid entry so
// the upstream ready can be a plain register without losing throughput.
module skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o
);

   // A beat moves on any edge where valid && ready are both high on that side;
   // valid never depends on ready, and held data stays frozen until taken.
   logic             out_valid_q, out_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             accept;
   logic             out_free;

   assign in_ready_o  = !skid_valid_q;
   assign accept      = in_valid_i && !skid_valid_q;
   assign out_free    = !out_valid_q || out_ready_i;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      out_data_d   = out_data_q;
      skid_data_d  = skid_data_q;
      if (flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free) begin
         // While the skid is occupied nothing new is accepted, so it drains first.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data_i;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_data_q   <= '0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_data_q   <= out_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I integer-ALU decode stage: decodes OP/OP-IMM/LUI/AUIPC into ALU
// operands and function, captured at acceptance into a skid-buffered output.
module decode_stage
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  alu_op,
   output logic        alu_op_mod,
   output logic [31:0] alu_lhs,
   output logic [31:0] alu_rhs,
   output logic [4:0]  rd_addr,
   output logic        rd_write,
   output logic        illegal
);

   dec_payload_t dec;
   dec_payload_t held;
   logic [6:0]   opcode;
   logic [6:0]   funct7;
   logic [2:0]   funct3;
   logic [31:0]  imm_i;
   logic [31:0]  imm_u;
   logic         legal;

   assign opcode   = in_instr[6:0];
   assign funct3   = in_instr[14:12];
   assign funct7   = in_instr[31:25];
   assign rs1_addr = in_instr[19:15];
   assign rs2_addr = in_instr[24:20];
   assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_u    = {in_instr[31:12], 12'h000};

   always_comb begin
      dec    = '0;
      legal  = 1'b0;
      dec.rd = in_instr[11:7];
      case (opcode)
         OPC_OP: begin
            dec.lhs    = rs1_data;
            dec.rhs    = rs2_data;
            dec.op     = alu_op_e'(funct3);
            dec.op_mod = in_instr[30];
            legal      = (funct7 == F7_BASE) ||
                         ((funct7 == F7_ALT) && ((funct3 == ALU_ADD) || (funct3 == ALU_SRL)));
         end
         OPC_OP_IMM: begin
            dec.lhs = rs1_data;
            dec.op  = alu_op_e'(funct3);
            // Immediate shifts carry only the shamt; funct7 is a selector, not operand.
            if (funct3 == ALU_SLL) begin
               dec.rhs = {27'd0, in_instr[24:20]};
               legal   = (funct7 == F7_BASE);
            end else if (funct3 == ALU_SRL) begin
               dec.rhs    = {27'd0, in_instr[24:20]};
               dec.op_mod = in_instr[30];
               legal      = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            end else begin
               dec.rhs = imm_i;
               legal   = 1'b1;
            end
         end
         OPC_LUI: begin
            dec.rhs = imm_u;
            legal   = 1'b1;
         end
         OPC_AUIPC: begin
            dec.lhs = in_pc;
            dec.rhs = imm_u;
            legal   = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      dec.illegal  = !legal;
      dec.rd_write = legal && (in_instr[11:7] != 5'd0);
   end

   skid_buffer #(
      .WIDTH($bits(dec_payload_t))
   ) u_skid (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (dec),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (held)
   );

   assign alu_op     = held.op;
   assign alu_op_mod = held.op_mod;
   assign alu_lhs    = held.lhs;
   assign alu_rhs    = held.rhs;
   assign rd_addr    = held.rd;
   assign rd_write   = held.rd_write;
   assign illegal    = held.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a queue-based reference of held instructions checked
// every cycle, plus directed vectors with hand-computed decoded results.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [2:0]  alu_op;
   logic        alu_op_mod;
   logic [31:0] alu_lhs, alu_rhs;
   logic [4:0]  rd_addr;
   logic        rd_write;
   logic        illegal;

   logic [74:0] dut_vec;
   logic [74:0] exp_q[$];
   logic [4:0]  rd_log[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   assign dut_vec = {alu_op, alu_op_mod, alu_lhs, alu_rhs, rd_addr, rd_write, illegal};

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog");
   end

   decode_stage dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_op     (alu_op),
      .alu_op_mod (alu_op_mod),
      .alu_lhs    (alu_lhs),
      .alu_rhs    (alu_rhs),
      .rd_addr    (rd_addr),
      .rd_write   (rd_write),
      .illegal    (illegal)
   );

   task automatic check(input string name, input logic [74:0] act, input logic [74:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [74:0] pk(input logic [2:0] op, input logic md,
                                      input logic [31:0] l, input logic [31:0] r,
                                      input logic [4:0] rd, input logic w, input logic ill);
      return {op, md, l, r, rd, w, ill};
   endfunction

   // Reference decode, straight from the instruction-set rules.
   function automatic logic [74:0] model(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [2:0]  op;
      logic        md;
      logic [31:0] l, r;
      bit          ok;
      f7 = ins[31:25];
      f3 = ins[14:12];
      op = 3'd0;
      md = 1'b0;
      l  = 32'd0;
      r  = 32'd0;
      ok = 1'b0;
      case (ins[6:0])
         7'h33: begin
            l = a; r = b; op = f3; md = ins[30];
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         end
         7'h13: begin
            l = a; op = f3;
            if (f3 == 3'd1 || f3 == 3'd5) begin
               r  = {27'd0, ins[24:20]};
               md = (f3 == 3'd5) && ins[30];
               ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f7 == 7'h00 || f7 == 7'h20);
            end else begin
               r  = {{20{ins[31]}}, ins[31:20]};
               ok = 1'b1;
            end
         end
         7'h37: begin r = {ins[31:12], 12'h000}; ok = 1'b1; end
         7'h17: begin l = pc; r = {ins[31:12], 12'h000}; ok = 1'b1; end
         default: ok = 1'b0;
      endcase
      return {op, md, l, r, ins[11:7], ok && (ins[11:7] != 5'd0), !ok};
   endfunction

   // Compare process: the stage holds at most two instructions, in order.
   always @(negedge clk) begin
      int occ;
      if (!reset_n) begin
         exp_q.delete();
      end else begin
         occ = exp_q.size();
         check("in_ready", 75'(in_ready), 75'(occ < 2));
         check("out_valid", 75'(out_valid), 75'(occ > 0));
         if (out_valid && occ > 0)
            check("payload", dut_vec, exp_q[0]);
         if (in_valid) begin
            check("rs1_addr", 75'(rs1_addr), 75'(in_instr[19:15]));
            check("rs2_addr", 75'(rs2_addr), 75'(in_instr[24:20]));
         end
         if (flush) begin
            exp_q.delete();
         end else begin
            if (out_valid && out_ready && occ > 0) begin
               rd_log.push_back(exp_q[0][6:2]);
               void'(exp_q.pop_front());
            end
            if (in_valid && occ < 2)
               exp_q.push_back(model(in_instr, in_pc, rs1_data, rs2_data));
         end
      end
   end

   // Driver: offer one instruction, return 1ns after the accepting edge.
   task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
      bit done;
      done     = 1'b0;
      in_instr = ins;
      in_pc    = pc;
      rs1_data = a;
      rs2_data = b;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      rs1_data = 32'hDEAD_BEEF;
      rs2_data = 32'hCAFE_F00D;
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: instr %h not accepted within 20 cycles, required acceptance", ins);
      end
   endtask

   task automatic vec(input string name, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b, input logic [74:0] exp);
      out_ready = 1'b1;
      send(ins, pc, a, b);
      check({name, "_valid"}, 75'(out_valid), 75'(1));
      check(name, dut_vec, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("reset_out_valid", 75'(out_valid), 75'(0));
      check("reset_in_ready", 75'(in_ready), 75'(1));
      check("reset_outputs", dut_vec, 75'(0));
      @(posedge clk);
      #1;

      // single instructions with out_ready high
      vec("add", 32'h002081B3, 32'h0, 32'd5, 32'd7, pk(3'd0, 1'b0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
      check("add_rs1_addr", 75'(rs1_addr), 75'(1));
      check("add_rs2_addr", 75'(rs2_addr), 75'(2));
      vec("srai", 32'h4030D213, 32'h0, 32'h8000_0000, 32'd0,
          pk(3'd5, 1'b1, 32'h8000_0000, 32'd3, 5'd4, 1'b1, 1'b0));
      vec("slli_bad", 32'h40309213, 32'h0, 32'h11, 32'd0,
          pk(3'd1, 1'b0, 32'h11, 32'd3, 5'd4, 1'b0, 1'b1));
      vec("sub", 32'h407302B3, 32'h0, 32'd10, 32'd3,
          pk(3'd0, 1'b1, 32'd10, 32'd3, 5'd5, 1'b1, 1'b0));
      vec("sll_bad", 32'h407312B3, 32'h0, 32'd6, 32'd9,
          pk(3'd1, 1'b1, 32'd6, 32'd9, 5'd5, 1'b0, 1'b1));
      vec("addi_x0", 32'hFFF00013, 32'h0, 32'd0, 32'd0,
          pk(3'd0, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0));
      vec("auipc", 32'h12345097, 32'h100, 32'd77, 32'd0,
          pk(3'd0, 1'b0, 32'h100, 32'h1234_5000, 5'd1, 1'b1, 1'b0));
      vec("lui", 32'hABCDE3B7, 32'h0, 32'd99, 32'd0,
          pk(3'd0, 1'b0, 32'd0, 32'hABCD_E000, 5'd7, 1'b1, 1'b0));
      vec("load_bad", 32'h0000A083, 32'h40, 32'd5, 32'd6,
          pk(3'd0, 1'b0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1));
      vec("sltu", 32'h0020B4B3, 32'h0, 32'd1, 32'd2,
          pk(3'd3, 1'b0, 32'd1, 32'd2, 5'd9, 1'b1, 1'b0));
      vec("srai_bad", 32'h6030D213, 32'h0, 32'd8, 32'd0,
          pk(3'd5, 1'b1, 32'd8, 32'd3, 5'd4, 1'b0, 1'b1));
      idle(2);

      // back-to-back with a two-cycle downstream stall
      rd_log.delete();
      out_ready = 1'b1;
      send(32'h00100093, 32'h0, 32'd0, 32'd0);
      out_ready = 1'b0;
      send(32'h00200113, 32'h0, 32'd0, 32'd0);
      @(negedge clk);
      check("stall_in_ready", 75'(in_ready), 75'(0));
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(32'h00300193, 32'h0, 32'd0, 32'd0);
      send(32'h00400213, 32'h0, 32'd0, 32'd0);
      idle(4);
      check("order_count", 75'(rd_log.size()), 75'(4));
      for (int i = 0; i < 4 && i < rd_log.size(); i++)
         check("order_rd", 75'(rd_log[i]), 75'(i + 1));

      // flush with both entries full and an instruction offered
      out_ready = 1'b0;
      send(32'h00500293, 32'h0, 32'd0, 32'd0);
      send(32'h00600313, 32'h0, 32'd0, 32'd0);
      in_instr = 32'h00700393;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      check("flush_out_valid", 75'(out_valid), 75'(0));
      check("flush_in_ready", 75'(in_ready), 75'(1));
      out_ready = 1'b1;
      idle(3);

      // flush with one entry held and in_ready high: offered instruction dropped
      out_ready = 1'b0;
      send(32'h00800413, 32'h0, 32'd0, 32'd0);
      in_instr = 32'h00900493;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      check("flush1_out_valid", 75'(out_valid), 75'(0));
      out_ready = 1'b1;
      idle(3);

      // asynchronous reset mid-stall
      out_ready = 1'b0;
      send(32'h00A00513, 32'h0, 32'd0, 32'd0);
      send(32'h0020B4B3, 32'h0, 32'd3, 32'd4);
      #2 reset_n = 1'b0;
      #1;
      check("areset_out_valid", 75'(out_valid), 75'(0));
      check("areset_outputs", dut_vec, 75'(0));
      check("areset_in_ready", 75'(in_ready), 75'(1));
      @(posedge clk);
      #1 reset_n = 1'b1;
      out_ready = 1'b1;
      idle(3);
      check("post_reset_out_valid", 75'(out_valid), 75'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
